// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg : shared types and constants for the conv_ctrl read sequencer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package conv_pkg;

    localparam int NUM_CH      = 4;
    localparam int KERNEL_SIZE = 9;
    localparam int PICT_W      = 9;
    localparam int IDX_W       = 2 * PICT_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WEIGHT = 3'd1,
        ST_DATA   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic             is_weight;
        logic [1:0]       ch;
        logic [IDX_W-1:0] idx;
        logic             conv_first;
        logic             inst_tag;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_addr_gen : FSM, k/p/ch counters and read address mux for conv_ctrl  |
// | Optional macro CONVCTRL_SIZE_CHECK_EN adds the P=0 size error path.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int KernelSize   = KERNEL_SIZE,
    parameter int MaxPictWidth = PICT_W,
    parameter int MaxAddrWidth = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic [NUM_CH-1:0][MaxAddrWidth-1:0] weight_addr_i,
    input  logic [NUM_CH-1:0][MaxAddrWidth-1:0] data_addr_i,
    input  logic [MaxPictWidth-1:0]             pict_size_i,
    input  logic                                conv_first_i,
    input  logic                                inst_tag_i,
    input  logic                                pipe_pending_i,
    output logic [MaxAddrWidth-1:0]             read_addr_o,
    output logic                                read_en_o,
    output tag_t                                tag_o,
    output logic                                busy_o,
    output logic                                done_o
`ifdef CONVCTRL_SIZE_CHECK_EN
    ,
    output logic                                err_o
`endif
);

    localparam int KW = (KernelSize > 1) ? $clog2(KernelSize) : 1;
    localparam int PW = 2 * MaxPictWidth;
    localparam logic [KW-1:0] K_LAST  = KW'(KernelSize - 1);
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [1:0]    CH_LAST = 2'(NUM_CH - 1);

    state_t                              state_q;
    logic [NUM_CH-1:0][MaxAddrWidth-1:0] waddr_q;
    logic [NUM_CH-1:0][MaxAddrWidth-1:0] daddr_q;
    logic [PW-1:0]                       psq_q;
    logic [PW-1:0]                       p_q;
    logic [KW-1:0]                       k_q;
    logic [1:0]                          ch_q;
    logic                                conv_first_q;
    logic                                inst_tag_q;
    logic                                read_en_q;
    logic [MaxAddrWidth-1:0]             read_addr_q;
    logic                                busy_q;
    logic                                done_q;
`ifdef CONVCTRL_SIZE_CHECK_EN
    logic                                err_q;
`endif

    logic [1:0]    ch_inc_d;
    logic [KW-1:0] k_inc_d;
    logic [PW-1:0] p_inc_d;
    logic [PW-1:0] psq_d;

    assign ch_inc_d = ch_q + 2'd1;
    assign k_inc_d  = k_q + K_ONE;
    assign p_inc_d  = p_q + P_ONE;
    assign psq_d    = PW'(pict_size_i) * PW'(pict_size_i);

    // Counters always name the read currently on read_addr_q, so the tag is a
    // direct view of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            daddr_q      <= '0;
            psq_q        <= '0;
            p_q          <= '0;
            k_q          <= '0;
            ch_q         <= '0;
            conv_first_q <= 1'b0;
            inst_tag_q   <= 1'b0;
            read_en_q    <= 1'b0;
            read_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CONVCTRL_SIZE_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        waddr_q      <= weight_addr_i;
                        daddr_q      <= data_addr_i;
                        psq_q        <= psq_d;
                        conv_first_q <= conv_first_i;
                        inst_tag_q   <= inst_tag_i;
                        k_q          <= '0;
                        p_q          <= '0;
                        ch_q         <= '0;
                        state_q      <= ST_WEIGHT;
                        read_en_q    <= 1'b1;
                        read_addr_q  <= weight_addr_i[0];
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
`ifdef CONVCTRL_SIZE_CHECK_EN
                        err_q        <= 1'b0;
                        if (pict_size_i == '0) begin
                            state_q   <= ST_DONE;
                            read_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                        end
`endif
                    end
                end
                ST_WEIGHT: begin
                    if (ch_q != CH_LAST) begin
                        ch_q        <= ch_inc_d;
                        read_addr_q <= waddr_q[ch_inc_d] + MaxAddrWidth'(k_q);
                    end else if (k_q != K_LAST) begin
                        ch_q        <= '0;
                        k_q         <= k_inc_d;
                        read_addr_q <= waddr_q[0] + MaxAddrWidth'(k_inc_d);
                    end else if (psq_q != '0) begin
                        ch_q        <= '0;
                        state_q     <= ST_DATA;
                        read_addr_q <= daddr_q[0];
                    end else begin
                        ch_q        <= '0;
                        state_q     <= ST_DRAIN;
                        read_en_q   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (ch_q != CH_LAST) begin
                        ch_q        <= ch_inc_d;
                        read_addr_q <= daddr_q[ch_inc_d] + MaxAddrWidth'(p_q);
                    end else if (p_q != psq_q - P_ONE) begin
                        ch_q        <= '0;
                        p_q         <= p_inc_d;
                        read_addr_q <= daddr_q[0] + MaxAddrWidth'(p_inc_d);
                    end else begin
                        ch_q        <= '0;
                        state_q     <= ST_DRAIN;
                        read_en_q   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The final read has left stage 1; it is on the output now.
                    if (!pipe_pending_i) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tag_o            = '0;
        tag_o.is_weight  = (state_q == ST_WEIGHT);
        tag_o.ch         = ch_q;
        tag_o.idx        = (state_q == ST_WEIGHT) ? IDX_W'(k_q) : IDX_W'(p_q);
        tag_o.conv_first = conv_first_q;
        tag_o.inst_tag   = inst_tag_q;
    end

    assign read_addr_o = read_addr_q;
    assign read_en_o   = read_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
`ifdef CONVCTRL_SIZE_CHECK_EN
    assign err_o       = err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/conv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_ctrl : read sequencer for the 4-channel 3x3 convolution engine      |
// | Optional macro CONVCTRL_SIZE_CHECK_EN adds err_out (P=0 rejection).      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int KernelSize   = KERNEL_SIZE,
    parameter int MaxPictWidth = PICT_W,
    parameter int MaxAddrWidth = 32
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      start_in,
    input  logic [MaxAddrWidth-1:0]   weight_addr0_in,
    input  logic [MaxAddrWidth-1:0]   weight_addr1_in,
    input  logic [MaxAddrWidth-1:0]   weight_addr2_in,
    input  logic [MaxAddrWidth-1:0]   weight_addr3_in,
    input  logic [MaxAddrWidth-1:0]   data_addr0_in,
    input  logic [MaxAddrWidth-1:0]   data_addr1_in,
    input  logic [MaxAddrWidth-1:0]   data_addr2_in,
    input  logic [MaxAddrWidth-1:0]   data_addr3_in,
    input  logic [MaxPictWidth-1:0]   pict_size_in,
    input  logic                      conv_first_in,
    input  logic                      inst_tag_in,
    input  logic [DataWidth-1:0]      read_rdata_in,
    output logic [MaxAddrWidth-1:0]   read_addr_out,
    output logic                      read_en_out,
    output logic [DataWidth-1:0]      out_data,
    output logic                      out_valid,
    output logic                      out_is_weight,
    output logic [1:0]                out_ch,
    output logic [2*MaxPictWidth-1:0] out_idx,
    output logic                      out_conv_first,
    output logic                      out_inst_tag,
    output logic                      busy_out,
    output logic                      done_out
`ifdef CONVCTRL_SIZE_CHECK_EN
    ,
    output logic                      err_out
`endif
);

    tag_t                 gen_tag;
    tag_t                 tag1_q;
    tag_t                 out_tag_q;
    logic                 v1_q;
    logic                 out_valid_q;
    logic [DataWidth-1:0] out_data_q;

    conv_addr_gen #(
        .KernelSize   (KernelSize),
        .MaxPictWidth (MaxPictWidth),
        .MaxAddrWidth (MaxAddrWidth)
    ) u_addr_gen (
        .clk            (Clk),
        .rst_n          (Rst_n),
        .start_i        (start_in),
        .weight_addr_i  ({weight_addr3_in, weight_addr2_in, weight_addr1_in, weight_addr0_in}),
        .data_addr_i    ({data_addr3_in, data_addr2_in, data_addr1_in, data_addr0_in}),
        .pict_size_i    (pict_size_in),
        .conv_first_i   (conv_first_in),
        .inst_tag_i     (inst_tag_in),
        .pipe_pending_i (v1_q),
        .read_addr_o    (read_addr_out),
        .read_en_o      (read_en_out),
        .tag_o          (gen_tag),
        .busy_o         (busy_out),
        .done_o         (done_out)
`ifdef CONVCTRL_SIZE_CHECK_EN
        ,
        .err_o          (err_out)
`endif
    );

    // Stage 1 pairs the tag with the in-flight read; stage 2 joins it with the
    // RAM word that arrives one cycle later.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            v1_q        <= 1'b0;
            tag1_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            v1_q        <= read_en_out;
            out_valid_q <= v1_q;
            if (read_en_out) begin
                tag1_q <= gen_tag;
            end
            if (v1_q) begin
                out_data_q <= read_rdata_in;
                out_tag_q  <= tag1_q;
            end
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_is_weight  = out_tag_q.is_weight;
    assign out_ch         = out_tag_q.ch;
    assign out_idx        = (2*MaxPictWidth)'(out_tag_q.idx);
    assign out_conv_first = out_tag_q.conv_first;
    assign out_inst_tag   = out_tag_q.inst_tag;

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_ctrl : self-checking bench for conv_ctrl with a read-order model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_conv_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int PWD = 9;
    localparam int IW  = 2 * PWD;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] wa [4];
    logic [AW-1:0] da [4];
    logic [PWD-1:0] pict_size_in = '0;
    logic          conv_first_in = 1'b0;
    logic          inst_tag_in = 1'b0;
    logic [DW-1:0] read_rdata_in = '0;
    logic [AW-1:0] read_addr_out;
    logic          read_en_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_is_weight;
    logic [1:0]    out_ch;
    logic [IW-1:0] out_idx;
    logic          out_conv_first;
    logic          out_inst_tag;
    logic          busy_out;
    logic          done_out;
`ifdef CONVCTRL_SIZE_CHECK_EN
    logic          err_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_wb [4];
    logic [AW-1:0] m_db [4];
    int            m_p;
    logic          m_cf;
    logic          m_tag;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          w;
        logic [1:0]    ch;
        logic [IW-1:0] idx;
    } rd_t;

    typedef struct packed {
        logic [DW-1:0] data;
        rd_t           rd;
        int            cyc;
    } out_t;

    always #5 Clk = ~Clk;

    conv_ctrl dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .start_in        (start_in),
        .weight_addr0_in (wa[0]),
        .weight_addr1_in (wa[1]),
        .weight_addr2_in (wa[2]),
        .weight_addr3_in (wa[3]),
        .data_addr0_in   (da[0]),
        .data_addr1_in   (da[1]),
        .data_addr2_in   (da[2]),
        .data_addr3_in   (da[3]),
        .pict_size_in    (pict_size_in),
        .conv_first_in   (conv_first_in),
        .inst_tag_in     (inst_tag_in),
        .read_rdata_in   (read_rdata_in),
        .read_addr_out   (read_addr_out),
        .read_en_out     (read_en_out),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_is_weight   (out_is_weight),
        .out_ch          (out_ch),
        .out_idx         (out_idx),
        .out_conv_first  (out_conv_first),
        .out_inst_tag    (out_inst_tag),
        .busy_out        (busy_out),
        .done_out        (done_out)
`ifdef CONVCTRL_SIZE_CHECK_EN
        ,
        .err_out         (err_out)
`endif
    );

    task automatic drive_junk(input bit allow_start);
        for (int i = 0; i < 4; i++) begin
            wa[i] = $urandom;
            da[i] = $urandom;
        end
        pict_size_in  = PWD'($urandom);
        conv_first_in = 1'($urandom);
        inst_tag_in   = 1'($urandom);
        start_in      = allow_start && ($urandom_range(0, 7) == 0);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({read_addr_out, read_en_out, out_data, out_valid, out_is_weight, out_ch, out_idx,
             out_conv_first, out_inst_tag, busy_out, done_out} !== '0) begin
            errors++;
            $display("FAIL %s outputs got addr=%h en=%b data=%h v=%b w=%b ch=%0d idx=%0d busy=%b done=%b required all zero",
                     name, read_addr_out, read_en_out, out_data, out_valid, out_is_weight, out_ch, out_idx,
                     busy_out, done_out);
        end
    endtask

    // One full operation from the model parameters, with junk on the inputs
    // (including stray start pulses) after the start has been accepted.
    task automatic run_op(input string name);
        rd_t  exp_rd[$];
        out_t pend[$];
        rd_t  r;
        out_t o;
        int   n_total;
        int   rd_cnt = 0, out_cnt = 0, first_rd = -1, last_rd = -1;
        int   last_out = -1, done_cyc = -1, c = 0, prev_idx = 0, prev_c = 0;
        bit   prev_rd = 0, busy_bad = 0;
        for (int k = 0; k < 9; k++)
            for (int ch = 0; ch < 4; ch++) begin
                r = '{addr: m_wb[ch] + AW'(k), w: 1'b1, ch: 2'(ch), idx: IW'(k)};
                exp_rd.push_back(r);
            end
        for (int p = 0; p < m_p * m_p; p++)
            for (int ch = 0; ch < 4; ch++) begin
                r = '{addr: m_db[ch] + AW'(p), w: 1'b0, ch: 2'(ch), idx: IW'(p)};
                exp_rd.push_back(r);
            end
        n_total = exp_rd.size();

        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            wa[i] = m_wb[i];
            da[i] = m_db[i];
        end
        pict_size_in  = PWD'(m_p);
        conv_first_in = m_cf;
        inst_tag_in   = m_tag;
        start_in      = 1'b1;

        while (c < n_total + 30 && done_cyc < 0) begin
            @(posedge Clk);
            #1;
            drive_junk(1'b1);
            read_rdata_in = $urandom;
            c++;
            @(negedge Clk);
            if (prev_rd && prev_idx < n_total) begin
                o = '{data: read_rdata_in, rd: exp_rd[prev_idx], cyc: prev_c};
                pend.push_back(o);
            end
            if (read_en_out) begin
                checks++;
                if (rd_cnt >= n_total) begin
                    errors++;
                    $display("FAIL %s extra_read got addr %h required no read", name, read_addr_out);
                end else if (read_addr_out !== exp_rd[rd_cnt].addr) begin
                    errors++;
                    $display("FAIL %s read_addr #%0d got %h required %h", name, rd_cnt, read_addr_out,
                             exp_rd[rd_cnt].addr);
                end
                if (first_rd < 0) first_rd = c;
                last_rd  = c;
                prev_idx = rd_cnt;
                prev_c   = c;
                rd_cnt++;
            end
            if (out_valid) begin
                checks++;
                if (pend.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_out got data %h required no output", name, out_data);
                end else begin
                    o = pend.pop_front();
                    if (out_data !== o.data) begin
                        errors++;
                        $display("FAIL %s out_data #%0d got %h required %h", name, out_cnt, out_data, o.data);
                    end
                    checks++;
                    if ({out_is_weight, out_ch, out_idx, out_conv_first, out_inst_tag} !==
                        {o.rd.w, o.rd.ch, o.rd.idx, m_cf, m_tag}) begin
                        errors++;
                        $display("FAIL %s out_tag #%0d got w=%b ch=%0d idx=%0d cf=%b tag=%b required w=%b ch=%0d idx=%0d cf=%b tag=%b",
                                 name, out_cnt, out_is_weight, out_ch, out_idx, out_conv_first, out_inst_tag,
                                 o.rd.w, o.rd.ch, o.rd.idx, m_cf, m_tag);
                    end
                    checks++;
                    if (c !== o.cyc + 2) begin
                        errors++;
                        $display("FAIL %s latency #%0d got %0d required %0d", name, out_cnt, c - o.cyc, 2);
                    end
                end
                last_out = c;
                out_cnt++;
            end
            if (!busy_out && !done_out) busy_bad = 1'b1;
            if (done_out) done_cyc = c;
            prev_rd = read_en_out;
        end
        start_in = 1'b0;

        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s done_timeout got no done after %0d cycles required done", name, c);
        end
        checks++;
        if (rd_cnt != n_total) begin
            errors++;
            $display("FAIL %s read_count got %0d required %0d", name, rd_cnt, n_total);
        end
        checks++;
        if (first_rd != 1 || last_rd - first_rd + 1 != rd_cnt) begin
            errors++;
            $display("FAIL %s read_burst got first=%0d last=%0d count=%0d required first=1 contiguous",
                     name, first_rd, last_rd, rd_cnt);
        end
        checks++;
        if (out_cnt != n_total) begin
            errors++;
            $display("FAIL %s out_count got %0d required %0d", name, out_cnt, n_total);
        end
        checks++;
        if (done_cyc != last_out + 1) begin
            errors++;
            $display("FAIL %s done_timing got %0d required %0d", name, done_cyc, last_out + 1);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy got low during run required high", name);
        end
`ifdef CONVCTRL_SIZE_CHECK_EN
        checks++;
        if (err_out !== 1'b0) begin
            errors++;
            $display("FAIL %s err_out got %b required 0", name, err_out);
        end
`endif
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            wa[i] = '0;
            da[i] = '0;
        end
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("reset_held");
`ifdef CONVCTRL_SIZE_CHECK_EN
        checks++;
        if (err_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b required 0", err_out);
        end
`endif
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_weight_data_order;
        for (int i = 0; i < 4; i++) begin
            m_wb[i] = AW'(9 * i);
            m_db[i] = AW'(128 + 36 * i);
        end
        m_p = 6; m_cf = 1'b1; m_tag = 1'b0;
        run_op("order_p6");
    endtask

    task automatic test_restart;
        for (int i = 0; i < 4; i++) begin
            m_wb[i] = AW'(36 + 9 * i);
            m_db[i] = AW'(272 + 36 * i);
        end
        m_p = 3; m_cf = 1'b0; m_tag = 1'b1;
        run_op("restart");
    endtask

    task automatic test_random;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) begin
                m_wb[i] = $urandom;
                m_db[i] = $urandom;
            end
            if (n == 0) begin
                m_wb[2] = 32'hFFFF_FFFC;
                m_db[1] = 32'hFFFF_FFFE;
            end
            m_p   = $urandom_range(1, 5);
            m_cf  = 1'($urandom);
            m_tag = 1'($urandom);
            run_op($sformatf("random%0d", n));
        end
    endtask

    task automatic test_p0;
`ifdef CONVCTRL_SIZE_CHECK_EN
        int reads = 0;
        @(posedge Clk);
        #1;
        pict_size_in = '0;
        start_in     = 1'b1;
        @(posedge Clk);
        #1;
        start_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (read_en_out) reads++;
        end
        checks++;
        if (reads != 0) begin
            errors++;
            $display("FAIL p0_reads got %0d required 0", reads);
        end
        checks++;
        if ({err_out, done_out, busy_out} !== 3'b110) begin
            errors++;
            $display("FAIL p0_flags got err=%b done=%b busy=%b required err=1 done=1 busy=0",
                     err_out, done_out, busy_out);
        end
`else
        for (int i = 0; i < 4; i++) begin
            m_wb[i] = $urandom;
            m_db[i] = $urandom;
        end
        m_p = 0; m_cf = 1'b1; m_tag = 1'b1;
        run_op("p0");
`endif
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            m_wb[i] = AW'(9 * i);
            m_db[i] = AW'(128 + 36 * i);
        end
        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            wa[i] = m_wb[i];
            da[i] = m_db[i];
        end
        pict_size_in = 9'd6;
        start_in     = 1'b1;
        @(posedge Clk);
        #1;
        start_in = 1'b0;
        repeat (50) begin
            @(posedge Clk);
            #1;
            read_rdata_in = $urandom;
        end
        @(negedge Clk);
        checks++;
        if (read_en_out !== 1'b1 || out_valid !== 1'b1 || out_is_weight !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_active got en=%b v=%b w=%b required en=1 v=1 w=0",
                     read_en_out, out_valid, out_is_weight);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_immediate");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (out_valid || read_en_out || busy_out || done_out) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles required 0", bad);
        end
        m_p = 2; m_cf = 1'b1; m_tag = 1'b1;
        run_op("after_reset");
    endtask

    initial begin
        test_reset();
        test_weight_data_order();
        test_restart();
        test_random();
        test_p0();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_ctrl.md
# conv_ctrl

Read sequencer for the 4-channel 3x3 convolution engine. On a start request it issues one RAM read per cycle: first the kernel weights of four input channels, then the pixels of four input pictures, channel-interleaved. Each returned word is forwarded downstream with a tag identifying phase, channel, element index, first-pass flag and instruction tag. It sits between the instruction decoder (addresses, picture size) and the accumulate/MAC array.

## Interface
- DataWidth, 32: RAM data word width.
- KernelSize, 9: weights per channel kernel (3x3).
- MaxPictWidth, 9: width of the picture-side field.
- MaxAddrWidth, 32: RAM address width.
- Clk  in  1: single clock. All logic is rising-edge.
- Rst_n  in  1: reset, asynchronous, active-low.
- start_in  in  1: single-cycle start pulse. Sampled only in IDLE and DONE.
- weight_addr0_in..weight_addr3_in  in  MaxAddrWidth each: kernel base address per channel.
- data_addr0_in..data_addr3_in  in  MaxAddrWidth each: picture base address per channel.
- pict_size_in  in  MaxPictWidth: picture side P. The picture is P x P.
- conv_first_in  in  1: first accumulation pass. Downstream overwrites instead of accumulating.
- inst_tag_in  in  1: instruction tag, forwarded unchanged.
- read_rdata_in  in  DataWidth: RAM read data, valid one cycle after read_en_out.
- read_addr_out  out  MaxAddrWidth: RAM read address.
- read_en_out  out  1: RAM read enable.
- out_data  out  DataWidth: returned word.
- out_valid  out  1: out_data and all tag outputs are valid this cycle.
- out_is_weight  out  1: 1 = weight word, 0 = pixel word.
- out_ch  out  2: channel 0..3.
- out_idx  out  2*MaxPictWidth: kernel index k or pixel index p.
- out_conv_first  out  1: latched conv_first_in.
- out_inst_tag  out  1: latched inst_tag_in.
- busy_out  out  1: high while reads are outstanding.
- done_out  out  1: high in DONE.
- err_out  out  1: size error flag. Present only when the check is compiled in (see Configuration).

## Operation
- States: IDLE, WEIGHT, DATA, DRAIN, DONE.
- IDLE or DONE + start_in → WEIGHT.
  - On this transition, latch all addresses, P, conv_first_in and inst_tag_in.
  - Clear the counters k, p and ch.
- WEIGHT: issue reads in the order k = 0..8; for each k, ch = 0..3.
  - read_addr_out = weight_addr[ch] + k.
  - That is 36 reads. After (k=8, ch=3) → DATA.
- DATA: issue reads in the order p = 0..P²−1; for each p, ch = 0..3.
  - read_addr_out = data_addr[ch] + p.
  - After (p=P²−1, ch=3) → DRAIN.
- DRAIN: wait until the last word has been output, then → DONE.
- read_en_out is high on every cycle in WEIGHT and DATA, with no bubbles. Total reads = 36 + 4·P².
- Address arithmetic:
  - Unsigned, modulo 2^MaxAddrWidth. Wrap-around is silent.
  - P² is computed as 2·MaxPictWidth bits.
- P = 0: the DATA phase is skipped. WEIGHT goes directly to DRAIN.
- start_in outside IDLE/DONE is ignored.
- Input changes after the start pulse have no effect on the running operation.
- busy_out is high in WEIGHT, DATA and DRAIN.

## Timing
- Read issued in cycle t: read_addr_out and read_en_out are registered and valid in cycle t.
- The RAM returns read_rdata_in in cycle t+1.
- The block registers it; out_data and out_valid appear in cycle t+2.
- Tags travel through a matching 2-stage pipeline.
- done_out rises on the cycle after the final out_valid.
- Reset values:
  - All outputs 0; state IDLE.
  - Pipeline valid bits cleared.
  - Internal latched inputs and counters 0.
- Reset asserted mid-operation: everything aborts immediately and asynchronously. No further out_valid until the next start.

## Configuration
- Macro CONVCTRL_SIZE_CHECK_EN.
- Defined:
  - err_out exists.
  - On start, if P = 0 or P > 2^MaxPictWidth−1 (unreachable; only P = 0 triggers), the block goes directly to DONE with err_out = 1 and issues no reads.
  - err_out clears on the next accepted start or on reset.
- Undefined:
  - err_out is absent.
  - P = 0 is handled as described in Operation.

## Structure
- Shared package conv_pkg holds:
  - the state enum;
  - the constants NUM_CH = 4 and KERNEL_SIZE = 9;
  - the tag struct {is_weight, ch, idx, conv_first, inst_tag}.
- One sub-module, conv_addr_gen:
  - contains the counters, the FSM and the address mux;
  - the top adds the 2-stage return pipeline.

## Test plan
- Weight order:
  - Stimulus: P=6; weight bases 0/9/18/27; data bases 128/164/200/236; start.
  - Required: the first 36 read addresses are 0,9,18,27,1,10,19,28,...,8,17,26,35, with out_is_weight = 1.
- Data order:
  - Same run.
  - Required: the next 144 reads are 128,164,200,236,129,... ending at 163,199,235,271.
  - read_en_out stays high for exactly 180 consecutive cycles.
- Latency:
  - Stimulus: random read_rdata_in.
  - Required: each out_data equals read_rdata_in from one cycle after its read.
  - out_ch and out_idx match the address order.
  - done_out rises exactly 1 cycle after the 180th out_valid.
- Reset mid-run:
  - Stimulus: assert Rst_n low during DATA.
  - Required: all outputs 0 immediately.
- Restart:
  - Stimulus: restart with weight bases 36/45/54/63, data base 272, conv_first=0, inst_tag=1.
  - Required: the addresses follow the new bases; out_conv_first = 0 and out_inst_tag = 1 throughout.
- P=0 edge case:
  - Required: 36 weight reads, then DONE.
  - With CONVCTRL_SIZE_CHECK_EN defined: zero reads and err_out = 1.
